// File: rtl/snake_pkg.sv
// Shared snake-game types: heading encoding, queue FSM states, opposite-direction helper.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_e;

  typedef enum logic {
    S_WAIT = 1'b0,
    S_RUN  = 1'b1
  } dirq_state_e;

  // Opposite headings differ only in the LSB.
  function automatic dir_e opposite(input dir_e d);
    return dir_e'({d[1], ~d[0]});
  endfunction

endpackage

// File: rtl/dir_fifo.sv
// Circular direction FIFO (power-of-two DEPTH); supports push and pop in the same cycle,
// including a push into a full queue when a pop frees the slot.
module dir_fifo
  import snake_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  dir_e                         push_data,
  input  logic                         pop,
  output dir_e                         head_data,
  output dir_e                         tail_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  dir_e          mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem[rd_ptr];
  assign tail_data = mem[wr_ptr - PW'(1)];

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/direction_queue.sv
// Snake heading queue: filters one-shot presses, buffers them, and pops one per game tick.
// Optional macro DIRQ_REVERSAL_FILTER_EN rejects presses opposite to the reference heading.
module direction_queue
  import snake_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        up_in,
  input  logic                        down_in,
  input  logic                        left_in,
  input  logic                        right_in,
  input  logic                        tick_in,
  output logic [1:0]                  dir_out,
  output logic                        move_out,
  output logic [$clog2(DEPTH+1)-1:0]  count_out,
  output logic                        overflow_out,
  output logic                        running_out
);

  dirq_state_e state;
  dir_e        dir_q;
  dir_e        cand;
  logic        cand_valid;
  dir_e        ref_dir;
  dir_e        head_dir;
  dir_e        tail_dir;
  logic        fifo_full;
  logic        fifo_empty;
  logic        accept;
  logic        pop_req;
  logic        push_fire;
  logic        overflow_evt;

  always_comb begin
    cand_valid = 1'b1;
    cand       = DIR_UP;
    case ({up_in, down_in, left_in, right_in})
      4'b1000: cand = DIR_UP;
      4'b0100: cand = DIR_DOWN;
      4'b0010: cand = DIR_LEFT;
      4'b0001: cand = DIR_RIGHT;
      default: cand_valid = 1'b0;
    endcase
  end

  // Compare against the newest queued heading so back-to-back presses filter correctly.
  assign ref_dir = fifo_empty ? dir_q : tail_dir;

  always_comb begin
    accept = cand_valid && (cand != ref_dir);
`ifdef DIRQ_REVERSAL_FILTER_EN
    if (cand == opposite(ref_dir)) accept = 1'b0;
`endif
  end

  assign pop_req      = (state == S_RUN) && tick_in && !fifo_empty;
  assign push_fire    = accept && (!fifo_full || pop_req);
  assign overflow_evt = accept && fifo_full && !pop_req;

  dir_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push_fire),
    .push_data (cand),
    .pop       (pop_req),
    .head_data (head_dir),
    .tail_data (tail_dir),
    .count     (count_out),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_WAIT;
      dir_q        <= DIR_RIGHT;
      move_out     <= 1'b0;
      overflow_out <= 1'b0;
    end else begin
      move_out <= (state == S_RUN) && tick_in;
      if (pop_req) dir_q <= head_dir;
      if (overflow_evt) overflow_out <= 1'b1;
      if (state == S_WAIT && push_fire) state <= S_RUN;
    end
  end

  assign dir_out     = dir_q;
  assign running_out = (state == S_RUN);

endmodule

// File: tb/tb_direction_queue.sv
// Self-checking bench for direction_queue (DEPTH=4); honours DIRQ_REVERSAL_FILTER_EN when defined.
module tb_direction_queue;

`ifdef DIRQ_REVERSAL_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif
  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       up_in = 1'b0, down_in = 1'b0, left_in = 1'b0, right_in = 1'b0, tick_in = 1'b0;
  logic [1:0] dir_out;
  logic       move_out;
  logic [2:0] count_out;
  logic       overflow_out;
  logic       running_out;

  int errors = 0;
  int checks = 0;

  // Scoreboard/model: expected entries pushed on accepted presses, popped on ticks.
  logic [1:0] m_q[$];
  logic [1:0] m_dir = 2'b11;
  logic       m_run = 1'b0;
  logic       m_ovf = 1'b0;
  logic       m_move = 1'b0;

  direction_queue #(.DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .up_in        (up_in),
    .down_in      (down_in),
    .left_in      (left_in),
    .right_in     (right_in),
    .tick_in      (tick_in),
    .dir_out      (dir_out),
    .move_out     (move_out),
    .count_out    (count_out),
    .overflow_out (overflow_out),
    .running_out  (running_out)
  );

  always #5 clock = ~clock;

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    {up_in, down_in, left_in, right_in, tick_in} = '0;
    m_q.delete();
    m_dir = 2'b11; m_run = 1'b0; m_ovf = 1'b0; m_move = 1'b0;
  endtask

  // press bits: {up, down, left, right}
  task automatic drive(input logic [3:0] press, input logic tick);
    logic [1:0] ref_d, cand;
    logic       acc, pop, was_full;
    {up_in, down_in, left_in, right_in} = press;
    tick_in = tick;
    ref_d = (m_q.size() > 0) ? m_q[$] : m_dir;
    case (press)
      4'b1000: cand = 2'b00;
      4'b0100: cand = 2'b01;
      4'b0010: cand = 2'b10;
      default: cand = 2'b11;
    endcase
    acc = ($countones(press) == 1) && (cand != ref_d) &&
          !(FILT && (cand == {ref_d[1], ~ref_d[0]}));
    was_full = (m_q.size() == DEPTH);
    pop = m_run && tick && (m_q.size() > 0);
    m_move = m_run && tick;
    if (pop) m_dir = m_q.pop_front();
    if (acc) begin
      if (!was_full || pop) begin
        m_q.push_back(cand);
        m_run = 1'b1;
      end else begin
        m_ovf = 1'b1;
      end
    end
    @(posedge clock); #1;
    {up_in, down_in, left_in, right_in, tick_in} = '0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (dir_out !== 2'b11) begin errors++; $display("FAIL reset_dir got=%0d exp=3", dir_out); end
    checks++; if (count_out !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count_out); end
    checks++; if ({move_out, overflow_out, running_out} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {move_out, overflow_out, running_out}); end
  endtask

  task automatic test_wait_ticks();
    for (int i = 0; i < 3; i++) begin
      drive(4'b0000, 1'b1);
      checks++; if ({move_out, running_out, dir_out} !== 4'b0011) begin errors++; $display("FAIL wait_tick%0d got move=%b run=%b dir=%0d exp move=0 run=0 dir=3", i, move_out, running_out, dir_out); end
    end
  endtask

  task automatic test_single_press();
    drive(4'b1000, 1'b0);
    checks++; if (count_out !== 3'd1 || running_out !== 1'b1) begin errors++; $display("FAIL press_up got count=%0d run=%b exp count=1 run=1", count_out, running_out); end
    drive(4'b0000, 1'b1);
    checks++; if (count_out !== 3'd0 || dir_out !== 2'b00 || move_out !== 1'b1) begin errors++; $display("FAIL tick_pop got count=%0d dir=%0d move=%b exp 0/0/1", count_out, dir_out, move_out); end
    drive(4'b0000, 1'b0);
    checks++; if (move_out !== 1'b0) begin errors++; $display("FAIL move_one_cycle got=%b exp=0", move_out); end
  endtask

  task automatic test_reversal();
    logic [2:0] exp_cnt;
    exp_cnt = FILT ? 3'd0 : 3'd1;
    drive(4'b0100, 1'b0);
    checks++; if (count_out !== exp_cnt) begin errors++; $display("FAIL reversal got count=%0d exp=%0d", count_out, exp_cnt); end
    checks++; if (overflow_out !== 1'b0) begin errors++; $display("FAIL reversal_flag got=%b exp=0", overflow_out); end
  endtask

  task automatic test_overflow();
    logic [3:0] seq [5];
    do_reset();
    seq = '{4'b0010, 4'b1000, 4'b0001, 4'b1000, 4'b0010};
    foreach (seq[i]) drive(seq[i], 1'b0);
    checks++; if (count_out !== 3'(m_q.size()) || overflow_out !== m_ovf) begin errors++; $display("FAIL overflow_fill got count=%0d ovf=%b exp count=%0d ovf=%b", count_out, overflow_out, m_q.size(), m_ovf); end
    if (!FILT) begin
      checks++; if (count_out !== 3'd4 || overflow_out !== 1'b1) begin errors++; $display("FAIL overflow_const got count=%0d ovf=%b exp 4/1", count_out, overflow_out); end
    end
    for (int i = 0; i < 4; i++) begin
      drive(4'b0000, 1'b1);
      checks++; if (dir_out !== m_dir || move_out !== 1'b1) begin errors++; $display("FAIL drain%0d got dir=%0d move=%b exp dir=%0d move=1", i, dir_out, move_out, m_dir); end
      checks++; if (overflow_out !== m_ovf) begin errors++; $display("FAIL ovf_sticky%0d got=%b exp=%b", i, overflow_out, m_ovf); end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(4'b1000, 1'b0); drive(4'b0010, 1'b0); drive(4'b0100, 1'b0); drive(4'b0001, 1'b0);
    checks++; if (count_out !== 3'd4) begin errors++; $display("FAIL b2b_fill got=%0d exp=4", count_out); end
    drive(4'b1000, 1'b1);
    checks++; if (count_out !== 3'd4 || overflow_out !== 1'b0 || dir_out !== 2'b00) begin errors++; $display("FAIL b2b_full_push got count=%0d ovf=%b dir=%0d exp 4/0/0", count_out, overflow_out, dir_out); end
    for (int i = 0; i < 4; i++) begin
      drive(4'b0000, 1'b1);
      checks++; if (dir_out !== m_dir) begin errors++; $display("FAIL b2b_pop%0d got=%0d exp=%0d", i, dir_out, m_dir); end
    end
    checks++; if (dir_out !== 2'b00 || count_out !== 3'd0) begin errors++; $display("FAIL b2b_last got dir=%0d count=%0d exp 0/0", dir_out, count_out); end
  endtask

  task automatic test_multi_press();
    drive(4'b1010, 1'b0);
    checks++; if (count_out !== 3'd0 || count_out !== 3'(m_q.size())) begin errors++; $display("FAIL multi_press got count=%0d exp=0", count_out); end
  endtask

  task automatic test_coincide_empty();
    drive(4'b0010, 1'b1);
    checks++; if (count_out !== 3'd1 || dir_out !== 2'b00 || move_out !== 1'b1) begin errors++; $display("FAIL no_bypass got count=%0d dir=%0d move=%b exp 1/0/1", count_out, dir_out, move_out); end
  endtask

  task automatic test_reset_mid();
    drive(4'b0100, 1'b0); drive(4'b0010, 1'b0);
    checks++; if (count_out !== 3'd3) begin errors++; $display("FAIL mid_fill got=%0d exp=3", count_out); end
    up_in = 1'b1; tick_in = 1'b1;
    do_reset();
    checks++; if (count_out !== 3'd0 || dir_out !== 2'b11 || {move_out, running_out, overflow_out} !== 3'b000) begin errors++; $display("FAIL mid_reset got count=%0d dir=%0d flags=%b exp 0/3/000", count_out, dir_out, {move_out, running_out, overflow_out}); end
    drive(4'b1000, 1'b0);
    checks++; if (count_out !== 3'd1 || running_out !== 1'b1) begin errors++; $display("FAIL post_reset_press got count=%0d run=%b exp 1/1", count_out, running_out); end
  endtask

  initial begin
    test_reset();
    test_wait_ticks();
    test_single_press();
    test_reversal();
    test_overflow();
    test_back_to_back();
    test_multi_press();
    test_coincide_empty();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
